// File: rtl/kernel_stream_writer.sv
// Loads conv2 weights from a byte stream into a single-port RAM, verifies the trailing checksum,
// and serves the weights to the kernel loader through a 1-cycle registered read port.
module kernel_stream_writer #(
  parameter int OC    = 16,
  parameter int IC    = 8,
  parameter int KSZ   = 9,
  parameter int DEPTH = OC * IC * KSZ,
  parameter int CHW   = IC * KSZ,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          s_valid_i,
  input  logic [7:0]    s_data_i,
  output logic          s_ready_o,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic [OC-1:0] ch_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);
  localparam int WW = (CHW > 1) ? $clog2(CHW) : 1;
  localparam int CW = (OC > 1) ? $clog2(OC) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  state_t        state_q;
  logic [AW-1:0] wr_cnt_q;
  logic [WW-1:0] word_q;
  logic [CW-1:0] ch_q;
  logic [7:0]    sum_q;
  logic [OC-1:0] ch_valid_q;
  logic          done_q, err_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem [DEPTH];

  logic       busy, accept, wr_en;
  logic [7:0] sum_d;

  assign busy      = (state_q == LOAD) || (state_q == CHECK);
  // The read port owns the RAM whenever rd_en is high; the stream simply waits.
  assign s_ready_o = busy && !rd_en_i && !start_i;
  assign accept    = s_valid_i && s_ready_o;
  assign wr_en     = accept && (state_q == LOAD);
  assign sum_d     = sum_q + s_data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      word_q     <= '0;
      ch_q       <= '0;
      sum_q      <= '0;
      ch_valid_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (start_i) begin
      state_q    <= LOAD;
      wr_cnt_q   <= '0;
      word_q     <= '0;
      ch_q       <= '0;
      sum_q      <= '0;
      ch_valid_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: if (accept) begin
          sum_q    <= sum_d;
          wr_cnt_q <= wr_cnt_q + 1'b1;
          if (word_q == WW'(CHW - 1)) begin
            word_q             <= '0;
            ch_valid_q[ch_q]   <= 1'b1;
            ch_q               <= ch_q + 1'b1;
          end else begin
            word_q <= word_q + 1'b1;
          end
          if (wr_cnt_q == AW'(DEPTH - 1)) state_q <= CHECK;
        end
        CHECK: if (accept) begin
          if (sum_d == 8'h00) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= ERR;
            err_q      <= 1'b1;
            ch_valid_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM contents deliberately survive reset and restarts.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= s_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= (rd_addr_i < AW'(DEPTH)) ? mem[rd_addr_i] : 8'h00;
  end

  assign rd_data_o  = rd_data_q;
  assign ch_valid_o = ch_valid_q;
  assign busy_o     = busy;
  assign done_o     = done_q;
  assign err_o      = err_q;
endmodule
